write_back_buffer: RTL and testbench
====================================

WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 2: number of 4-word line entries buffered (power of two, 2..8).
REQ-002 SHALL provide parameter ADDR_W, default 15: main-memory word address width.
REQ-003 SHALL provide parameter DATA_W, default 32: word width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 wbValid  input  1  cache offers an evicted line.
REQ-008 wbReady  output  1  buffer can accept a line this cycle.
REQ-009 wbAddress  input  ADDR_W  any word address inside the evicted line.
REQ-010 wbW3, wbW2, wbW1, wbW0  input  DATA_W each  line words at offsets 3..0.
REQ-011 memWrite  output  1  write request to main memory.
REQ-012 memReady  input  1  main memory accepts the current word.
REQ-013 memAddress  output  ADDR_W  word address being written.
REQ-014 memData  output  DATA_W  word being written.
REQ-015 snoopAddress  input  ADDR_W  read address checked against pending lines.
REQ-016 snoopHit  output  1  a pending line covers snoopAddress.
REQ-017 snoopW3, snoopW2, snoopW1, snoopW0  output  DATA_W each  words of the matching line.
REQ-018 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-019 drained  output  1  buffer empty and no write in progress.

Function
REQ-020 SHALL store each accepted line with its base address = wbAddress with bits [1:0] cleared.
REQ-021 SHALL accept a line on any rising edge where wbValid and wbReady are both high; wbReady SHALL be (count < DEPTH), with no combinational path from memReady or any pop.
REQ-022 SHALL hold lines in FIFO order; circular read/write pointers wrap from DEPTH-1 to 0.
REQ-023 SHALL implement drain FSM states IDLE and WRITE with a 2-bit beat counter.
REQ-024 IDLE -> WRITE on the edge after count becomes nonzero; beat = 0 on entry.
REQ-025 In WRITE: memWrite = 1, memAddress = head base + beat, memData = head word[beat] (beat 0 -> W0 ... beat 3 -> W3).
REQ-026 Beat SHALL advance only on an edge with memWrite and memReady both high; memAddress/memData SHALL stay stable while memReady is low.
REQ-027 On acceptance of beat 3: pop head, beat -> 0; remain in WRITE if another entry remains (no idle cycle between lines), else -> IDLE.
REQ-028 Latency: first memWrite one cycle after the accepting edge into an empty IDLE buffer; a line with memReady held high drains in exactly 4 cycles.
REQ-029 Push and pop on the same edge SHALL leave count unchanged; the push is possible only when count < DEPTH before that edge.
REQ-030 memWrite SHALL be 0 in IDLE; memAddress/memData are don't-care when memWrite = 0.
REQ-031 snoopHit SHALL be combinational: high if snoopAddress[ADDR_W-1:2] equals the base[ADDR_W-1:2] of any occupied entry, the head included, until its beat 3 is accepted.
REQ-032 On multiple matches, snoop outputs SHALL come from the newest matching entry; snoop words are 0 when snoopHit = 0.
REQ-033 drained = (count == 0) and state IDLE.
REQ-034 Word addresses SHALL wrap modulo 2^ADDR_W (base + beat never carries past bit 1).

Reset
REQ-035 While rst is low: count = 0, pointers = 0, state IDLE, beat = 0, memWrite = 0, wbReady = 0, snoopHit = 0, drained = 1.
REQ-036 Reset asserted mid-line SHALL discard all pending lines immediately; no further memWrite until new lines are accepted.
REQ-037 Entry data storage need not be cleared by reset.

Verification
REQ-038 Push line wbAddress=0x0006, words W0..W3 = 0xA0..0xA3, memReady=1 -> memWrite for 4 cycles at 0x0004..0x0007 with data 0xA0..0xA3, then drained=1.
REQ-039 Push two lines back-to-back (bases 0x0010, 0x0020) with memReady=1 -> 8 consecutive memWrite cycles, no gap, addresses 0x0010..0x0013 then 0x0020..0x0023.
REQ-040 Hold memReady=0 for 3 cycles during beat 1 -> memAddress/memData frozen at beat 1; push a third line with DEPTH=2 full -> wbReady=0, line not accepted.
REQ-041 Pending line at base 0x0040, snoopAddress=0x0042 -> snoopHit=1 with that line's words; snoopAddress=0x0044 -> snoopHit=0, words 0.
REQ-042 Two pending lines both at base 0x0040 (old words 0x1x, new 0x2x) -> snoop returns 0x2x words.
REQ-043 Assert rst during beat 2 of a line -> memWrite=0 and count=0 during reset; after release, drained=1 and no write occurs.

Source files
------------

// File: rtl/write_back_buffer.sv
// Write-back buffer: queues evicted 4-word cache lines and drains them to main memory one
// word per accepted beat, with a combinational snoop port for reads that hit pending lines.
module write_back_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic [ADDR_W-1:0] wbAddress,
  input  logic [DATA_W-1:0] wbW3,
  input  logic [DATA_W-1:0] wbW2,
  input  logic [DATA_W-1:0] wbW1,
  input  logic [DATA_W-1:0] wbW0,
  output logic              memWrite,
  input  logic              memReady,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memData,
  input  logic [ADDR_W-1:0] snoopAddress,
  output logic              snoopHit,
  output logic [DATA_W-1:0] snoopW3,
  output logic [DATA_W-1:0] snoopW2,
  output logic [DATA_W-1:0] snoopW1,
  output logic [DATA_W-1:0] snoopW0,
  output logic [CW-1:0]     count,
  output logic              drained
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  // Only the line-index bits are stored; the word offset is always zero for a base.
  logic [ADDR_W-3:0] tag_mem  [DEPTH];
  logic [DATA_W-1:0] word_mem [DEPTH][4];

  logic [DATA_W-1:0] wb_words    [4];
  logic [DATA_W-1:0] snoop_words [4];
  logic              push;
  logic              pop;

  assign wb_words[0] = wbW0;
  assign wb_words[1] = wbW1;
  assign wb_words[2] = wbW2;
  assign wb_words[3] = wbW3;

  // Gated by rst so the buffer reports not-ready while held in reset.
  assign wbReady = rst & (count_q < CW'(DEPTH));
  assign push    = wbValid & wbReady;
  assign pop     = (state_q == WRITE) & memReady & (beat_q == 2'd3);

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= wbAddress[ADDR_W-1:2];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_word_store
    always_ff @(posedge clk) begin
      if (push) begin
        word_mem[wr_ptr_q][gi] <= wb_words[gi];
      end
    end
  end

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    state_d  = state_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WRITE;
          beat_d  = 2'd0;
        end
      end
      WRITE: begin
        if (memReady) begin
          beat_d = beat_q + 2'd1;
          // Stay in WRITE across lines so consecutive lines stream without a gap.
          if (beat_q == 2'd3 && count_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign memWrite   = (state_q == WRITE);
  assign memAddress = {tag_mem[rd_ptr_q], beat_q};
  assign memData    = word_mem[rd_ptr_q][beat_q];
  assign count      = count_q;
  assign drained    = (count_q == '0) && (state_q == IDLE);

  // Walk from oldest to newest so the newest matching entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    snoopHit = 1'b0;
    for (int w = 0; w < 4; w++) begin
      snoop_words[w] = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (tag_mem[idx] == snoopAddress[ADDR_W-1:2])) begin
        snoopHit = 1'b1;
        for (int w = 0; w < 4; w++) begin
          snoop_words[w] = word_mem[idx][w];
        end
      end
    end
  end

  assign snoopW0 = snoop_words[0];
  assign snoopW1 = snoop_words[1];
  assign snoopW2 = snoop_words[2];
  assign snoopW3 = snoop_words[3];

endmodule

// File: tb/tb_write_back_buffer.sv
// Testbench for write_back_buffer: directed scenarios plus a randomized run against a
// line-queue reference model.
module tb_write_back_buffer;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              wbValid;
  logic              wbReady;
  logic [ADDR_W-1:0] wbAddress;
  logic [DATA_W-1:0] wbW3, wbW2, wbW1, wbW0;
  logic              memWrite;
  logic              memReady;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memData;
  logic [ADDR_W-1:0] snoopAddress;
  logic              snoopHit;
  logic [DATA_W-1:0] snoopW3, snoopW2, snoopW1, snoopW0;
  logic [CW-1:0]     count;
  logic              drained;

  int total = 0;
  int bad   = 0;

  write_back_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wbValid(wbValid), .wbReady(wbReady), .wbAddress(wbAddress),
    .wbW3(wbW3), .wbW2(wbW2), .wbW1(wbW1), .wbW0(wbW0),
    .memWrite(memWrite), .memReady(memReady), .memAddress(memAddress), .memData(memData),
    .snoopAddress(snoopAddress), .snoopHit(snoopHit),
    .snoopW3(snoopW3), .snoopW2(snoopW2), .snoopW1(snoopW1), .snoopW0(snoopW0),
    .count(count), .drained(drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] b);
    wbAddress = a;
    wbW0 = b; wbW1 = b + 1; wbW2 = b + 2; wbW3 = b + 3;
  endtask

  task automatic test_reset();
    rst = 1'b0; wbValid = 1'b1; memReady = 1'b1; snoopAddress = '0;
    set_line(15'h0000, 32'h0);
    tick(); tick();
    total++; if (wbReady !== 1'b0) begin bad++; $display("FAIL reset_wbReady got=%b exp=0", wbReady); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (memWrite !== 1'b0) begin bad++; $display("FAIL reset_memWrite got=%b exp=0", memWrite); end
    total++; if (snoopHit !== 1'b0) begin bad++; $display("FAIL reset_snoopHit got=%b exp=0", snoopHit); end
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL reset_drained got=%b exp=1", drained); end
    wbValid = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (wbReady !== 1'b1) begin bad++; $display("FAIL post_reset_wbReady got=%b exp=1", wbReady); end
    $display("test_reset done");
  endtask

  task automatic test_single_line();
    memReady = 1'b1;
    wbValid = 1'b1;
    set_line(15'h0006, 32'hA0);
    tick();
    wbValid = 1'b0;
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (memWrite !== 1'b0) begin bad++; $display("FAIL single_idle_memWrite got=%b exp=0", memWrite); end
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (memWrite !== 1'b1 || memAddress !== ADDR_W'(4 + k) || memData !== DATA_W'(32'hA0 + k)) begin
        bad++;
        $display("FAIL single_beat%0d got=%b/%h/%h exp=1/%h/%h", k, memWrite, memAddress, memData, 4 + k, 32'hA0 + k);
      end
      tick();
    end
    total++; if (drained !== 1'b1 || memWrite !== 1'b0) begin bad++; $display("FAIL single_drained got=%b/%b exp=1/0", drained, memWrite); end
    $display("test_single_line done");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    memReady = 1'b1;
    wbValid = 1'b1;
    set_line(15'h0010, 32'h100);
    tick();
    set_line(15'h0020, 32'h200);
    tick();
    wbValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ea = (k < 4) ? ADDR_W'(15'h0010 + k) : ADDR_W'(15'h0020 + k - 4);
      ed = (k < 4) ? DATA_W'(32'h100 + k) : DATA_W'(32'h200 + k - 4);
      total++;
      if (memWrite !== 1'b1 || memAddress !== ea || memData !== ed) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%b/%h/%h exp=1/%h/%h", k, memWrite, memAddress, memData, ea, ed);
      end
      tick();
    end
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b exp=1", drained); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall_full();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    memReady = 1'b1;
    wbValid = 1'b1;
    set_line(15'h0030, 32'h300);
    tick();
    set_line(15'h0050, 32'h500);
    tick();
    tick();
    memReady = 1'b0;
    wbValid = 1'b1;
    set_line(15'h0060, 32'h600);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (wbReady !== 1'b0 || count !== CW'(2)) begin
        bad++; $display("FAIL stall_full%0d got=%b/%0d exp=0/2", c, wbReady, count);
      end
      total++;
      if (memWrite !== 1'b1 || memAddress !== 15'h0031 || memData !== 32'h301) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/0031/301", c, memWrite, memAddress, memData);
      end
      tick();
    end
    wbValid = 1'b0;
    memReady = 1'b1;
    for (int k = 1; k < 8; k++) begin
      ea = (k < 4) ? ADDR_W'(15'h0030 + k) : ADDR_W'(15'h0050 + k - 4);
      ed = (k < 4) ? DATA_W'(32'h300 + k) : DATA_W'(32'h500 + k - 4);
      total++;
      if (memWrite !== 1'b1 || memAddress !== ea || memData !== ed) begin
        bad++;
        $display("FAIL stall_drain%0d got=%b/%h/%h exp=1/%h/%h", k, memWrite, memAddress, memData, ea, ed);
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (memWrite !== 1'b0 || drained !== 1'b1) begin
        bad++; $display("FAIL stall_no_third%0d got=%b/%b exp=0/1", c, memWrite, drained);
      end
      tick();
    end
    $display("test_stall_full done");
  endtask

  task automatic test_snoop();
    int waited;
    memReady = 1'b0;
    wbValid = 1'b1;
    set_line(15'h0040, 32'h10);
    tick();
    wbValid = 1'b0;
    snoopAddress = 15'h0042;
    #1;
    total++;
    if (snoopHit !== 1'b1 || snoopW0 !== 32'h10 || snoopW1 !== 32'h11 || snoopW2 !== 32'h12 || snoopW3 !== 32'h13) begin
      bad++; $display("FAIL snoop_hit got=%b/%h/%h/%h/%h exp=1/10/11/12/13", snoopHit, snoopW0, snoopW1, snoopW2, snoopW3);
    end
    snoopAddress = 15'h0044;
    #1;
    total++;
    if (snoopHit !== 1'b0 || snoopW0 !== '0 || snoopW1 !== '0 || snoopW2 !== '0 || snoopW3 !== '0) begin
      bad++; $display("FAIL snoop_miss got=%b/%h/%h/%h/%h exp=0/0/0/0/0", snoopHit, snoopW0, snoopW1, snoopW2, snoopW3);
    end
    wbValid = 1'b1;
    set_line(15'h0041, 32'h20);
    tick();
    wbValid = 1'b0;
    snoopAddress = 15'h0042;
    #1;
    total++;
    if (snoopHit !== 1'b1 || snoopW0 !== 32'h20 || snoopW1 !== 32'h21 || snoopW2 !== 32'h22 || snoopW3 !== 32'h23) begin
      bad++; $display("FAIL snoop_newest got=%b/%h/%h/%h/%h exp=1/20/21/22/23", snoopHit, snoopW0, snoopW1, snoopW2, snoopW3);
    end
    memReady = 1'b1;
    waited = 0;
    while (drained !== 1'b1 && waited < 30) begin
      tick();
      waited++;
    end
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL snoop_drain_timeout got=%b exp=1", drained); end
    total++; if (snoopHit !== 1'b0) begin bad++; $display("FAIL snoop_after_drain got=%b exp=0", snoopHit); end
    $display("test_snoop done");
  endtask

  task automatic test_reset_mid_line();
    memReady = 1'b1;
    wbValid = 1'b1;
    set_line(15'h0070, 32'h700);
    tick();
    wbValid = 1'b0;
    tick(); tick(); tick();
    total++;
    if (memWrite !== 1'b1 || memAddress !== 15'h0072) begin
      bad++; $display("FAIL mid_beat2 got=%b/%h exp=1/0072", memWrite, memAddress);
    end
    rst = 1'b0;
    #1;
    total++;
    if (memWrite !== 1'b0 || count !== '0 || drained !== 1'b1) begin
      bad++; $display("FAIL mid_in_reset got=%b/%0d/%b exp=0/0/1", memWrite, count, drained);
    end
    tick(); tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (memWrite !== 1'b0 || drained !== 1'b1) begin
        bad++; $display("FAIL mid_after_reset%0d got=%b/%b exp=0/1", c, memWrite, drained);
      end
    end
    $display("test_reset_mid_line done");
  endtask

  typedef struct packed {
    logic [ADDR_W-1:0]      base;
    logic [3:0][DATA_W-1:0] w;
  } line_t;

  task automatic test_random();
    line_t                  q[$];
    line_t                  nl;
    bit                     in_write;
    int                     beats;
    int                     size_pre;
    bit                     do_push;
    bit                     e_hit;
    logic [3:0][DATA_W-1:0] e_sw;
    logic [ADDR_W-1:0]      e_addr;
    int                     errs_before;
    in_write = 1'b0;
    beats = 0;
    errs_before = bad;
    for (int cyc = 0; cyc < 600; cyc++) begin
      wbValid      = ($urandom_range(0, 1) == 1);
      wbAddress    = ADDR_W'($urandom_range(0, 63));
      wbW0 = $urandom; wbW1 = $urandom; wbW2 = $urandom; wbW3 = $urandom;
      memReady     = ($urandom_range(0, 9) < 7);
      snoopAddress = ADDR_W'($urandom_range(0, 63));
      #1;
      total++;
      if (wbReady !== (q.size() < DEPTH) || count !== CW'(q.size())) begin
        bad++; $display("FAIL rnd_occupancy cyc=%0d got=%b/%0d exp=%b/%0d", cyc, wbReady, count, q.size() < DEPTH, q.size());
      end
      total++;
      if (drained !== (q.size() == 0 && !in_write) || memWrite !== in_write) begin
        bad++; $display("FAIL rnd_status cyc=%0d got=%b/%b exp=%b/%b", cyc, drained, memWrite, q.size() == 0 && !in_write, in_write);
      end
      if (in_write) begin
        e_addr = q[0].base + ADDR_W'(beats);
        total++;
        if (memAddress !== e_addr || memData !== q[0].w[beats]) begin
          bad++; $display("FAIL rnd_write cyc=%0d got=%h/%h exp=%h/%h", cyc, memAddress, memData, e_addr, q[0].w[beats]);
        end
      end
      e_hit = 1'b0;
      e_sw  = '0;
      foreach (q[i]) begin
        if (q[i].base[ADDR_W-1:2] == snoopAddress[ADDR_W-1:2]) begin
          e_hit = 1'b1;
          e_sw  = q[i].w;
        end
      end
      total++;
      if (snoopHit !== e_hit || {snoopW3, snoopW2, snoopW1, snoopW0} !== e_sw) begin
        bad++; $display("FAIL rnd_snoop cyc=%0d addr=%h got=%b/%h exp=%b/%h", cyc, snoopAddress, snoopHit,
                        {snoopW3, snoopW2, snoopW1, snoopW0}, e_hit, e_sw);
      end
      @(posedge clk);
      size_pre = q.size();
      do_push  = wbValid && (size_pre < DEPTH);
      nl.base  = {wbAddress[ADDR_W-1:2], 2'b00};
      nl.w     = {wbW3, wbW2, wbW1, wbW0};
      if (!in_write) begin
        if (size_pre > 0) begin
          in_write = 1'b1;
          beats = 0;
        end
        if (do_push) q.push_back(nl);
      end else begin
        if (memReady) beats++;
        if (beats == 4) begin
          void'(q.pop_front());
          beats = 0;
          if (do_push) q.push_back(nl);
          in_write = (q.size() > 0);
        end else if (do_push) begin
          q.push_back(nl);
        end
      end
      #1;
    end
    wbValid = 1'b0;
    $display("test_random done errors=%0d", bad - errs_before);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_line();
    test_back_to_back();
    test_stall_full();
    test_snoop();
    test_reset_mid_line();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
